// File: rtl/mf_pll_pkg.sv
// Shared types and helpers for the PLL reset supervisor.
package mf_pll_pkg;

    // Supervisor FSM states.
    typedef enum logic [2:0] {
        PRST  = 3'd0,
        WAIT  = 3'd1,
        STAB  = 3'd2,
        RETRY = 3'd3,
        RUN   = 3'd4,
        FAIL  = 3'd5
    } pll_state_t;

    // Counter width: clog2 of the largest cycle parameter, plus one bit of headroom.
    function automatic int cnt_width(input int hold_cyc, input int stable_cyc, input int timeout_cyc);
        int m;
        m = hold_cyc;
        if (stable_cyc > m) m = stable_cyc;
        if (timeout_cyc > m) m = timeout_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/mf_sync2.sv
// Two-flop synchronizer for asynchronous status inputs, reset to 0.
module mf_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back capture stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mf_pll_reset_ctrl.sv
// PLL supervisor: pulses PLL reset, waits for debounced lock with timeout and
// bounded retries, then releases the system reset. Lock loss restarts the PLL.
module mf_pll_reset_ctrl
    import mf_pll_pkg::*;
#(
    parameter int RESET_HOLD_CYC   = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [3:0] attempt,
    output logic [7:0] relock_count
);

    localparam int CW = cnt_width(RESET_HOLD_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [3:0]    RETRY_LAST   = 4'(MAX_RETRIES);

    logic          lk;
    pll_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] stab, stab_nxt;
    logic [3:0]    attempt_nxt;
    logic [7:0]    relock_nxt;
    logic          pll_rst_nxt, sys_rst_nxt, pll_ready_nxt, pll_fail_nxt;

    mf_sync2 #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // Next-state, counter and output decode; outputs derive from the next state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stab_nxt    = stab;
        attempt_nxt = attempt;
        relock_nxt  = relock_count;

        if (relock_req) begin
            state_nxt   = PRST;
            cnt_nxt     = '0;
            stab_nxt    = '0;
            attempt_nxt = '0;
        end else begin
            case (state)
                PRST: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == TIMEOUT_LAST) begin
                        state_nxt = RETRY;
                    end else if (lk) begin
                        // The lk cycle seen here already counts as the first stable cycle.
                        state_nxt = (LOCK_STABLE_CYC == 1) ? RUN : STAB;
                        stab_nxt  = '0;
                    end
                end
                STAB: begin
                    cnt_nxt  = cnt + 1'b1;
                    stab_nxt = stab + 1'b1;
                    if (cnt == TIMEOUT_LAST) begin
                        state_nxt = RETRY;
                    end else if (!lk) begin
                        state_nxt = WAIT;
                        stab_nxt  = '0;
                    end else if (stab_nxt == STABLE_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RETRY: begin
                    cnt_nxt  = '0;
                    stab_nxt = '0;
                    if (attempt == RETRY_LAST) begin
                        state_nxt = FAIL;
                    end else begin
                        attempt_nxt = attempt + 4'd1;
                        state_nxt   = PRST;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        if (relock_count != 8'hFF) relock_nxt = relock_count + 8'd1;
                        attempt_nxt = '0;
                        cnt_nxt     = '0;
                        stab_nxt    = '0;
                        state_nxt   = PRST;
                    end
                end
                FAIL: begin
                    state_nxt = FAIL;
                end
                default: begin
                    state_nxt = PRST;
                    cnt_nxt   = '0;
                    stab_nxt  = '0;
                end
            endcase
        end

        pll_rst_nxt   = (state_nxt == PRST) || (state_nxt == FAIL);
        sys_rst_nxt   = (state_nxt != RUN);
        pll_ready_nxt = (state_nxt == RUN);
        pll_fail_nxt  = (state_nxt == FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= PRST;
            cnt          <= '0;
            stab         <= '0;
            attempt      <= '0;
            relock_count <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            pll_ready    <= 1'b0;
            pll_fail     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            stab         <= stab_nxt;
            attempt      <= attempt_nxt;
            relock_count <= relock_nxt;
            pll_rst      <= pll_rst_nxt;
            sys_rst      <= sys_rst_nxt;
            pll_ready    <= pll_ready_nxt;
            pll_fail     <= pll_fail_nxt;
        end
    end

endmodule
